// File: rtl/reg_load_sequencer.sv
// Write-side sequencer for the 4-bit load-enabled register: buffers nibbles,
// issues one spaced load_n pulse per nibble and checks the readback on q.
module reg_load_sequencer #(
    parameter int DEPTH = 4,
    parameter int GAP   = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_data,
    output logic                   load_n,
    output logic [3:0]             d,
    input  logic [3:0]             q,
    input  logic                   err_clr,
    output logic                   verify_err,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [1:0] {IDLE, LOAD, CHECK, WAIT} state_t;

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [3:0]    mem [DEPTH];
    logic [3:0]    gap_cnt;
    logic [3:0]    gap_nx;
    logic          load_n_nx;
    logic [3:0]    d_nx;
    logic          err_nx;
    logic          empty;
    logic          push;
    logic          pop;

    assign empty    = (count == '0);
    assign in_ready = (count < FULL);
    assign busy     = (state != IDLE) || !empty;
    assign push     = in_valid && in_ready;
    assign pop      = (state == IDLE) && !empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (!empty) state_nx = LOAD;
            LOAD:    state_nx = CHECK;
            CHECK:   state_nx = (GAP == 0) ? IDLE : WAIT;
            WAIT:    if (gap_cnt <= 4'd1) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // A mismatch found on the same edge as err_clr must win, so set after clear.
    always_comb begin
        load_n_nx = 1'b1;
        d_nx      = d;
        gap_nx    = gap_cnt;
        err_nx    = verify_err;
        if (err_clr) err_nx = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    load_n_nx = 1'b0;
                    d_nx      = mem[rd_ptr];
                end
            end
            CHECK: begin
                if (q != d) err_nx = 1'b1;
                gap_nx = 4'(GAP);
            end
            WAIT:    gap_nx = gap_cnt - 4'd1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            load_n     <= 1'b1;
            d          <= '0;
            verify_err <= 1'b0;
            gap_cnt    <= '0;
        end else begin
            load_n     <= load_n_nx;
            d          <= d_nx;
            verify_err <= err_nx;
            gap_cnt    <= gap_nx;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !push) begin
                count <= count - CNT_ONE;
            end
        end
    end

    // Storage needs no reset: a flush only has to rewind the pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end
endmodule
